// File: rtl/vga_timing_mixer.sv
// vga_timing_mixer: free-running VGA raster generator (default 640x480@60).
// Publishes the current pixel coordinate to the colour sources, then registers
// the selected colour together with hsync/vsync so colour and sync leave the
// block aligned, one clock after the pixel is presented on x/y.
module vga_timing_mixer #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  input  logic [5:0] overlay_rgb,
  input  logic       overlay_active,
  input  logic [5:0] bg_rgb,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] vga_out,
  output logic [7:0] frame_count,
  output logic       frame_tick
);

  localparam int unsigned CNT_W    = 10;
  // One extra bit so window bounds equal to 1024 still compare correctly
  localparam int unsigned WIN_W    = CNT_W + 1;
  localparam int unsigned RGB_W    = 6;
  localparam int unsigned FC_W     = 8;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_STOP  = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_STOP  = VS_START + V_SYNC;

  // Reject timings the 10-bit counters cannot represent
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_timing
    $error("vga_timing_mixer: H_TOTAL and V_TOTAL must be in 1..1024");
  end

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             tick_q, tick_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_end;
  logic             frame_end;
  logic             h_win;
  logic             v_win;

  // Raster position decodes
  assign line_end  = (x_q == CNT_W'(H_TOTAL - 1));
  assign frame_end = line_end && (y_q == CNT_W'(V_TOTAL - 1));

  assign frame_active = (WIN_W'(x_q) < WIN_W'(H_VISIBLE)) &&
                        (WIN_W'(y_q) < WIN_W'(V_VISIBLE));

  // Sync windows; vsync is decoded per pixel from y, not line-aligned to hsync
  assign h_win = (WIN_W'(x_q) >= WIN_W'(HS_START)) && (WIN_W'(x_q) < WIN_W'(HS_STOP));
  assign v_win = (WIN_W'(y_q) >= WIN_W'(VS_START)) && (WIN_W'(y_q) < WIN_W'(VS_STOP));

  // Raster counters, frame counter and frame-start pulse
  always_comb begin
    x_d    = x_q + CNT_W'(1);
    y_d    = y_q;
    fc_d   = fc_q;
    tick_d = 1'b0;
    if (line_end) begin
      x_d = '0;
      y_d = y_q + CNT_W'(1);
    end
    if (frame_end) begin
      y_d    = '0;
      fc_d   = fc_q + FC_W'(1);
      tick_d = 1'b1;
    end
  end

  // Colour select and sync polarity for the pixel currently on x/y
  always_comb begin
    rgb_d = '0;
    if (frame_active) begin
      rgb_d = overlay_active ? overlay_rgb : bg_rgb;
    end
    hsync_d = ~h_win;
    vsync_d = ~v_win;
  end

  // State and output registers; sync outputs idle high in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      tick_q  <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      tick_q  <= tick_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_count = fc_q;
  assign frame_tick  = tick_q;

  // PMOD pin order: {hsync, B0, G0, R0, vsync, B1, G1, R1}
  assign vga_out = {hsync_q, rgb_q[0], rgb_q[2], rgb_q[4],
                    vsync_q, rgb_q[1], rgb_q[3], rgb_q[5]};

endmodule

// File: tb/tb_vga_timing_mixer.sv
// Bench for vga_timing_mixer: a full-size instance for line timing and
// colour mixing, and a shrunken-raster instance driven with random colours
// against a scoreboard across many frames, including a mid-frame reset.
module tb_vga_timing_mixer;

  localparam int unsigned SHV = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int unsigned SVV = 3, SVF = 1, SVS = 2, SVB = 1;
  localparam int unsigned SHT = SHV + SHF + SHS + SHB;   // 8
  localparam int unsigned SVT = SVV + SVF + SVS + SVB;   // 7
  localparam int unsigned SFRAME = SHT * SVT;            // 56
  localparam int unsigned NFRAMES = 258;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_f, rst_n_s;

  logic [9:0] f_x, f_y;
  logic       f_fa, f_ova, f_hs, f_vs, f_tick;
  logic [5:0] f_ov, f_bg, f_rgb;
  logic [7:0] f_vga, f_fc;

  logic [9:0] s_x, s_y;
  logic       s_fa, s_ova, s_hs, s_vs, s_tick;
  logic [5:0] s_ov, s_bg, s_rgb;
  logic [7:0] s_vga, s_fc;

  vga_timing_mixer u_full (
    .clk(clk), .rst_n(rst_n_f), .x(f_x), .y(f_y), .frame_active(f_fa),
    .overlay_rgb(f_ov), .overlay_active(f_ova), .bg_rgb(f_bg), .rgb(f_rgb),
    .hsync(f_hs), .vsync(f_vs), .vga_out(f_vga), .frame_count(f_fc),
    .frame_tick(f_tick)
  );

  vga_timing_mixer #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .rst_n(rst_n_s), .x(s_x), .y(s_y), .frame_active(s_fa),
    .overlay_rgb(s_ov), .overlay_active(s_ova), .bg_rgb(s_bg), .rgb(s_rgb),
    .hsync(s_hs), .vsync(s_vs), .vga_out(s_vga), .frame_count(s_fc),
    .frame_tick(s_tick)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       tick;
    logic [7:0] fc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned mx, my;
  logic [7:0]  mfc;

  function automatic logic [7:0] vga_pack(input logic [5:0] c, input logic hs, input logic vs);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // Drive random colours for the pixel on x/y and queue what must come out next edge
  task automatic sb_drive_push();
    exp_t e;
    logic vis;
    s_bg  = 6'($urandom);
    s_ov  = 6'($urandom);
    s_ova = 1'($urandom);
    vis    = (mx < SHV) && (my < SVV);
    e.rgb  = !vis ? 6'd0 : (s_ova ? s_ov : s_bg);
    e.hs   = !(mx >= SHV + SHF && mx < SHV + SHF + SHS);
    e.vs   = !(my >= SVV + SVF && my < SVV + SVF + SVS);
    e.tick = (mx == SHT - 1) && (my == SVT - 1);
    if (mx == SHT - 1) begin
      mx = 0;
      if (my == SVT - 1) begin
        my  = 0;
        mfc = mfc + 8'd1;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    e.fc = mfc;
    sb_q.push_back(e);
  endtask

  // Pop the expected output for the pixel just registered and check position
  task automatic sb_check();
    exp_t e;
    chk("sb_level", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("s_out", {s_vga, s_fc, s_tick, s_vs, s_hs, s_rgb},
        {vga_pack(e.rgb, e.hs, e.vs), e.fc, e.tick, e.vs, e.hs, e.rgb});
    chk("s_pos", {s_fa, s_y, s_x},
        {((mx < SHV) && (my < SVV)), 10'(my), 10'(mx)});
  endtask

  initial begin
    int unsigned n_falls, first_fall_x, first_fall_c, period, low_run, hs_width;
    int unsigned last_tick, ticks, vs_low, wrap_seen;
    logic        h_prev;
    logic [7:0]  prev_fc;

    rst_n_f = 1'b0; rst_n_s = 1'b0;
    f_bg = 6'b100100; f_ov = 6'd0; f_ova = 1'b0;
    s_bg = 6'd0; s_ov = 6'd0; s_ova = 1'b0;
    mx = 0; my = 0; mfc = 8'd0;

    // Full-size instance: reset values
    repeat (5) begin
      @(posedge clk); #1;
      chk("f_rst_vga", 32'(f_vga), 32'h88);
      chk("f_rst_xy", {f_y, f_x}, 32'd0);
      chk("f_rst_misc", {f_rgb, f_fc, f_tick}, 32'd0);
    end
    @(negedge clk); rst_n_f = 1'b1;

    n_falls = 0; first_fall_x = 0; first_fall_c = 0; period = 0;
    low_run = 0; hs_width = 0; h_prev = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      @(posedge clk); #1;
      if (!f_hs && h_prev) begin
        n_falls++;
        low_run = 0;
        if (n_falls == 1) begin
          first_fall_x = 32'(f_x);
          first_fall_c = c;
        end else if (n_falls == 2) begin
          period = c - first_fall_c;
        end
      end
      if (!f_hs) low_run++;
      if (f_hs && !h_prev && n_falls == 1 && hs_width == 0) hs_width = low_run;
      h_prev = f_hs;

      case (c)
        1: begin
          chk("f_first_x", 32'(f_x), 32'd1);
          chk("f_first_rgb", 32'(f_rgb), 32'b100100);
          chk("f_first_vga", 32'(f_vga), 32'hA9);
          chk("f_first_tick", 32'(f_tick), 32'd0);
        end
        50: begin
          chk("f_fa_vis", 32'(f_fa), 32'd1);
          chk("f_bg0", 32'(f_rgb), 32'b100100);
          f_bg = 6'b000011;
        end
        51: begin
          chk("f_bg1", 32'(f_rgb), 32'b000011);
          chk("f_bg1_vga", 32'(f_vga), 32'hCC);
          f_ova = 1'b1; f_ov = 6'b111111;
        end
        52: begin
          chk("f_ovl", 32'(f_rgb), 32'b111111);
          chk("f_ovl_vga", 32'(f_vga), 32'hFF);
          f_ova = 1'b0; f_ov = 6'd0;
        end
        700: begin
          chk("f_blank_x", 32'(f_x), 32'd700);
          chk("f_fa_blank", 32'(f_fa), 32'd0);
          f_ova = 1'b1; f_ov = 6'b111111; f_bg = 6'b111111;
        end
        701: begin
          chk("f_blank_rgb", 32'(f_rgb), 32'd0);
          chk("f_blank_vga", 32'(f_vga), 32'h08);
          f_ova = 1'b0; f_ov = 6'd0; f_bg = 6'b000011;
        end
        default: ;
      endcase
    end
    chk("f_hs_first_x", first_fall_x, 32'd657);
    chk("f_hs_width", hs_width, 32'd96);
    chk("f_line_period", period, 32'd800);
    chk("f_end_pos", {f_y, f_x}, {10'd2, 10'd100});

    // Small instance: reset values, then a few pixels before a mid-frame reset
    @(posedge clk); #1;
    chk("s_rst_out", {s_vga, s_fc, s_tick, s_rgb}, {8'h88, 15'd0});
    chk("s_rst_xy", {s_y, s_x}, 32'd0);
    @(negedge clk); rst_n_s = 1'b1;
    sb_drive_push();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      sb_check();
      sb_drive_push();
    end
    #2; rst_n_s = 1'b0; #1;
    chk("s_arst_out", {s_vga, s_fc, s_tick, s_rgb}, {8'h88, 15'd0});
    chk("s_arst_xy", {s_y, s_x}, 32'd0);
    sb_q.delete();
    mx = 0; my = 0; mfc = 8'd0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("s_rst_hold", {s_y, s_x, s_fc}, 32'd0);
    end
    @(negedge clk); rst_n_s = 1'b1;
    sb_drive_push();

    last_tick = 0; ticks = 0; vs_low = 0; wrap_seen = 0; prev_fc = 8'd0;
    for (int c = 1; c <= int'(NFRAMES * SFRAME) + 5; c++) begin
      @(posedge clk); #1;
      sb_check();
      if (!s_vs) vs_low++;
      if (s_tick) begin
        ticks++;
        chk("s_tick_gap", c - last_tick, SFRAME);
        chk("s_vs_frame", vs_low, SVS * SHT);
        if (prev_fc == 8'd255 && s_fc == 8'd0) wrap_seen++;
        last_tick = c;
        vs_low = 0;
      end
      prev_fc = s_fc;
      sb_drive_push();
    end
    chk("s_ticks", ticks, NFRAMES);
    chk("s_fc_wrap", wrap_seen, 32'd1);
    chk("s_fc_end", 32'(s_fc), 32'(NFRAMES % 256));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_mixer.md
# vga_timing_mixer

Generates 640x480@60 VGA raster timing, publishes the current pixel coordinate to the overlay and background generators, and merges their returned colour with the sync signals into registered VGA PMOD outputs. It sits at the top of the video path. It is the source of `x`, `y` and `frame_active`, and the sink of `overlay_rgb`/`overlay_active` and the background colour. It also provides a frame counter and a frame tick for animation logic.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch

Ports:
- `clk` in 1: pixel clock, nominal 25.175 MHz, single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `x` out 10: current column counter, registered
- `y` out 10: current line counter, registered
- `frame_active` out 1: combinational, `x < H_VISIBLE && y < V_VISIBLE`
- `overlay_rgb` in 6: {R1,R0,G1,G0,B1,B0}, combinational function of `x`/`y`
- `overlay_active` in 1: overlay owns this pixel
- `bg_rgb` in 6: background colour for the current `x`/`y`, same format
- `rgb` out 6: registered final colour
- `hsync` out 1: registered, active-low
- `vsync` out 1: registered, active-low
- `vga_out` out 8: {hsync, B0, G0, R0, vsync, B1, G1, R1}, wired directly from the registered `rgb`/`hsync`/`vsync`
- `frame_count` out 8: completed-frame counter
- `frame_tick` out 1: one-cycle pulse at each frame start

## Operation
- Counter widths:
  - `H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK` (800).
  - `V_TOTAL` is defined the same way (525).
  - Both totals must be ≤ 1024. The counters are 10-bit unsigned.
- `x` increments every clock. At `x == H_TOTAL-1`, `x` wraps to 0 and `y` increments.
- At `x == H_TOTAL-1 && y == V_TOTAL-1`, both wrap to 0 in the same cycle.
- Sync windows:
  - Horizontal sync window: `H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC`, which is 656..751.
  - Vertical sync window: `V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC`, which is 490..491.
  - `vsync` is evaluated per pixel from `y`, so it is not line-aligned to hsync.
- Output stage, registered every clock from the current `x`/`y`:
  - `rgb` gets `bg_rgb` or `overlay_rgb`, selected as follows:
    - `!frame_active` gives 0.
    - Otherwise `overlay_active` gives `overlay_rgb`.
    - Otherwise the result is `bg_rgb`.
  - `hsync` gets the inverse of the horizontal sync window.
  - `vsync` gets the inverse of the vertical sync window.
- `frame_count` increments, modulo 256, on the same edge that wraps `x` and `y` to 0/0. It wraps from 255 to 0.
- `frame_tick` is registered high for exactly the one cycle in which `x == 0 && y == 0` are presented, excluding the reset cycle.
- Reset: while `rst_n` is low, and asynchronously on assertion:
  - `x = 0`, `y = 0`
  - `rgb = 0`
  - `hsync = 1`, `vsync = 1`
  - `frame_count = 0`, `frame_tick = 0`
  - `vga_out = 8'b1000_1000`
- Reset mid-frame: all state returns to the reset values immediately. After release, counting restarts at 0/0 with no partial-frame increment of `frame_count`.

## Timing
- Latency: `x`/`y`/`frame_active` are valid from a clock edge. Colour sources settle combinationally in the same cycle. `rgb`, `hsync`, `vsync` and `vga_out` reflect that pixel one clock later.
- The sync outputs carry the same 1-cycle delay as `rgb`, so colour and sync stay mutually aligned.
- First edge after `rst_n` is released: `x` becomes 1, and outputs show pixel (0,0) with `rgb` = the colour for (0,0).
- There is no stall or enable. The raster runs freely, and the colour sources must meet a single-cycle combinational path from `x`/`y`.
- Frame period is 420000 clocks. Line period is 800 clocks.

## Test plan
- Reset behaviour:
  - Stimulus: hold `rst_n` low for 5 cycles, then release.
  - Required: `vga_out == 8'h88` and `x == y == 0` during reset, and `x == 1` one edge after release.
- Horizontal sync placement:
  - Stimulus: run one line.
  - Required: `hsync` is low for exactly 96 consecutive cycles, first low output when `x == 657`, i.e. pixel 656 delayed by 1. Line period is 800.
- Vertical sync placement:
  - Stimulus: run one full frame.
  - Required: `vsync` is low for exactly 1600 cycles, covering lines 490–491.
  - Required: `frame_tick` pulses once per 420000 cycles, and `frame_count` goes from 0 to 1.
- Colour mixing:
  - Stimulus: `bg_rgb = 6'b00_00_11` with overlay inactive.
  - Required: `rgb == 6'b000011` at visible pixels.
  - Stimulus: set `overlay_active = 1`, `overlay_rgb = 6'b111111`.
  - Required: `rgb == 6'b111111`.
  - Stimulus: both sources driven while `x == 700` (blanking).
  - Required: `rgb == 0` at the following output.
- Frame counter wrap:
  - Stimulus: force or run 256 frames.
  - Required: `frame_count` goes from 255 to 0 coincident with `frame_tick`.
- Reset mid-frame:
  - Stimulus: assert `rst_n` low at x=300, y=200, then release.
  - Required: immediate reset values on assertion. `frame_count` is unchanged at 0, and the next `frame_tick` occurs exactly 420000 cycles after release.
